// File: rtl/temp_pkg.sv
// Shared encodings for the temperature-driven fan controller: state codes,
// one-hot class constants, duty percentages and the class decoder.
package temp_pkg;

    typedef enum logic [1:0] {
        ST_LOW    = 2'b00,
        ST_NORMAL = 2'b01,
        ST_HIGH   = 2'b10,
        ST_DANGER = 2'b11
    } state_t;

    localparam logic [3:0] CLS_LOW    = 4'b1000;
    localparam logic [3:0] CLS_NORMAL = 4'b0100;
    localparam logic [3:0] CLS_HIGH   = 4'b0010;
    localparam logic [3:0] CLS_DANGER = 4'b0001;

    localparam int unsigned DUTY_PCT_LOW    = 0;
    localparam int unsigned DUTY_PCT_NORMAL = 25;
    localparam int unsigned DUTY_PCT_HIGH   = 60;
    localparam int unsigned DUTY_PCT_DANGER = 100;

    typedef struct packed {
        state_t cls;
        logic   bad;
    } sample_t;

    // Anything that is not exactly one-hot is treated as danger and flagged.
    function automatic sample_t decode_class(input logic [3:0] tc);
        sample_t s;
        s.cls = ST_DANGER;
        s.bad = 1'b0;
        case (tc)
            CLS_LOW:    s.cls = ST_LOW;
            CLS_NORMAL: s.cls = ST_NORMAL;
            CLS_HIGH:   s.cls = ST_HIGH;
            CLS_DANGER: s.cls = ST_DANGER;
            default:    s.bad = 1'b1;
        endcase
        return s;
    endfunction

    function automatic int unsigned duty_of(input state_t s, input int unsigned period);
        case (s)
            ST_LOW:    return period * DUTY_PCT_LOW / 100;
            ST_NORMAL: return period * DUTY_PCT_NORMAL / 100;
            ST_HIGH:   return period * DUTY_PCT_HIGH / 100;
            default:   return period * DUTY_PCT_DANGER / 100;
        endcase
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Fan PWM generator: free-running period counter, duty register that only
// reloads at the period wrap, and a registered comparator output.
module pwm_gen #(
    parameter int unsigned PERIOD = 100,
    parameter int unsigned DUTY_W = $clog2(PERIOD + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DUTY_W-1:0] duty_in,
    output logic              pwm
);

    logic [DUTY_W-1:0] cnt, cnt_nxt;
    logic [DUTY_W-1:0] duty, duty_nxt;
    logic              wrap;

    // NOTE: every always_comb output gets a default on every path, otherwise a latch is inferred.
    always_comb begin
        wrap     = (cnt == DUTY_W'(PERIOD - 1));
        cnt_nxt  = wrap ? '0 : cnt + DUTY_W'(1);
        duty_nxt = wrap ? duty_in : duty;
    end

    // pwm is compared against next-cycle values so the registered output
    // equals (cnt < duty) on every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            duty <= '0;
            pwm  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            cnt  <= cnt_nxt;
            duty <= duty_nxt;
            pwm  <= (cnt_nxt < duty_nxt);
        end
    end

endmodule

// File: rtl/temp_fan_ctrl.sv
// Temperature-class FSM with sample debounce, immediate danger entry,
// sticky error flag, alarm blinker and PWM fan drive.
module temp_fan_ctrl
    import temp_pkg::*;
#(
    parameter int unsigned PWM_PERIOD = 100,
    parameter int unsigned DEB_CNT    = 4,
    parameter int unsigned BLINK_DIV  = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] temp_class,
    input  logic       sample_en,
    output logic       fan_pwm,
    output logic       alarm_led,
    output logic [1:0] state,
    output logic       err_flag
);

    localparam int unsigned DUTY_W  = $clog2(PWM_PERIOD + 1);
    localparam int unsigned DEB_W   = $clog2(DEB_CNT + 1);
    localparam int unsigned BLINK_W = $clog2((BLINK_DIV > 1) ? BLINK_DIV : 2);

    state_t             st, st_nxt;
    state_t             cand, cand_nxt;
    logic [DEB_W-1:0]   deb_cnt, deb_cnt_nxt;
    logic [BLINK_W-1:0] blink_cnt;
    sample_t            samp;
    logic [DUTY_W-1:0]  duty_sel;

    always_comb begin
        samp        = decode_class(temp_class);
        st_nxt      = st;
        cand_nxt    = cand;
        deb_cnt_nxt = deb_cnt;
        if (sample_en) begin
            if (samp.cls == cand) begin
                deb_cnt_nxt = (deb_cnt == DEB_W'(DEB_CNT)) ? deb_cnt : deb_cnt + DEB_W'(1);
            end else begin
                cand_nxt    = samp.cls;
                deb_cnt_nxt = DEB_W'(1);
            end
            // Danger bypasses the debounce; other classes need a full run.
            if (samp.cls == ST_DANGER)
                st_nxt = ST_DANGER;
            else if (deb_cnt_nxt == DEB_W'(DEB_CNT))
                st_nxt = cand_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= ST_NORMAL;
            cand      <= ST_NORMAL;
            deb_cnt   <= '0;
            blink_cnt <= '0;
            alarm_led <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            st       <= st_nxt;
            cand     <= cand_nxt;
            deb_cnt  <= deb_cnt_nxt;
            err_flag <= err_flag | (sample_en & samp.bad);
            if (st_nxt == ST_DANGER) begin
                if (st != ST_DANGER) begin
                    alarm_led <= 1'b1;
                    blink_cnt <= '0;
                end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                    alarm_led <= ~alarm_led;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end else begin
                alarm_led <= (st_nxt == ST_HIGH);
                blink_cnt <= '0;
            end
        end
    end

    assign state    = st;
    assign duty_sel = DUTY_W'(duty_of(st, PWM_PERIOD));

    pwm_gen #(
        .PERIOD (PWM_PERIOD),
        .DUTY_W (DUTY_W)
    ) u_pwm (
        .clk     (clk),
        .reset   (reset),
        .duty_in (duty_sel),
        .pwm     (fan_pwm)
    );

endmodule

// File: tb/tb_temp_fan_ctrl.sv
// Directed bench for temp_fan_ctrl with PWM_PERIOD=100, DEB_CNT=4, BLINK_DIV=10.
module tb_temp_fan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_en;
    logic [3:0] temp_class;
    logic       fan_pwm;
    logic       alarm_led;
    logic [1:0] state;
    logic       err_flag;

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    always #5 clk = ~clk;

    temp_fan_ctrl #(
        .PWM_PERIOD (100),
        .DEB_CNT    (4),
        .BLINK_DIV  (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .temp_class (temp_class),
        .sample_en  (sample_en),
        .fan_pwm    (fan_pwm),
        .alarm_led  (alarm_led),
        .state      (state),
        .err_flag   (err_flag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic [3:0] c);
        temp_class = c;
        sample_en  = 1'b1;
        tick();
        sample_en  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pwm_ones(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (fan_pwm === 1'b1) ones++;
        end
    endtask

    initial begin
        int ones;
        reset      = 1'b1;
        sample_en  = 1'b0;
        temp_class = 4'b0100;
        do_reset();

        // Reset state
        check("rst_state", 32'(state), 32'd1);
        check("rst_pwm",   32'(fan_pwm), 32'd0);
        check("rst_alarm", 32'(alarm_led), 32'd0);
        check("rst_err",   32'(err_flag), 32'd0);

        // Four HIGH samples with idle gaps: change only on the fourth
        for (int i = 0; i < 3; i++) begin
            strobe(4'b0010);
            ticks(2);
        end
        check("high_3rd_state", 32'(state), 32'd1);
        strobe(4'b0010);
        check("high_4th_state", 32'(state), 32'd2);
        check("high_alarm",     32'(alarm_led), 32'd1);
        ticks(100);
        pwm_ones(100, ones);
        check("high_duty", 32'(ones), 32'd60);

        // Re-sampling the current class changes nothing
        strobe(4'b0010);
        strobe(4'b0010);
        check("high_resample_state", 32'(state), 32'd2);
        check("high_resample_alarm", 32'(alarm_led), 32'd1);

        // Interrupted runs never reach four
        do_reset();
        for (int i = 0; i < 3; i++) strobe(4'b0010);
        check("interrupt_a", 32'(state), 32'd1);
        strobe(4'b0100);
        check("interrupt_b", 32'(state), 32'd1);
        for (int i = 0; i < 3; i++) strobe(4'b0010);
        check("interrupt_c", 32'(state), 32'd1);
        check("interrupt_alarm", 32'(alarm_led), 32'd0);
        strobe(4'b0010);
        check("interrupt_4th", 32'(state), 32'd2);

        // Inputs ignored without sample_en: debounce count held at 3
        do_reset();
        for (int i = 0; i < 3; i++) strobe(4'b0010);
        for (int i = 0; i < 200; i++) begin
            logic [7:0] v;
            v = 8'(i);
            temp_class = v[3:0];
            tick();
        end
        check("idle_state", 32'(state), 32'd1);
        check("idle_err",   32'(err_flag), 32'd0);
        strobe(4'b0010);
        check("idle_count_kept", 32'(state), 32'd2);

        // Single danger sample: immediate entry, blink every 10, full fan
        do_reset();
        strobe(4'b0001);
        check("danger_state", 32'(state), 32'd3);
        check("danger_alarm_entry", 32'(alarm_led), 32'd1);
        check("danger_err", 32'(err_flag), 32'd0);
        ones = 0;
        for (int j = 1; j <= 250; j++) begin
            tick();
            check($sformatf("blink_%0d", j), 32'(alarm_led), 32'(((j / 10) % 2) == 0));
            if (j > 100 && j <= 200 && fan_pwm === 1'b1) ones++;
        end
        check("danger_duty", 32'(ones), 32'd100);

        // Bad code while in DANGER sets the flag, then reset mid-blink
        strobe(4'b1100);
        check("danger_bad_err", 32'(err_flag), 32'd1);
        check("danger_bad_state", 32'(state), 32'd3);
        reset = 1'b1;
        tick();
        check("mid_rst_state", 32'(state), 32'd1);
        check("mid_rst_pwm",   32'(fan_pwm), 32'd0);
        check("mid_rst_alarm", 32'(alarm_led), 32'd0);
        check("mid_rst_err",   32'(err_flag), 32'd0);
        reset = 1'b0;
        // Period restarts at 0 with duty 0; NORMAL duty 25 loads at the wrap
        for (int k = 1; k <= 130; k++) begin
            tick();
            check($sformatf("restart_pwm_%0d", k), 32'(fan_pwm), 32'(k >= 100 && k < 125));
        end

        // Non-one-hot enters DANGER, sticky error survives debounced exit
        strobe(4'b0110);
        check("bad_state", 32'(state), 32'd3);
        check("bad_err",   32'(err_flag), 32'd1);
        for (int i = 0; i < 3; i++) strobe(4'b0100);
        check("bad_exit_3rd", 32'(state), 32'd3);
        strobe(4'b0100);
        check("bad_exit_4th", 32'(state), 32'd1);
        check("bad_err_held", 32'(err_flag), 32'd1);
        check("bad_exit_alarm", 32'(alarm_led), 32'd0);
        strobe(4'b0000);
        check("zero_state", 32'(state), 32'd3);
        for (int i = 0; i < 4; i++) strobe(4'b1000);
        check("low_state", 32'(state), 32'd0);
        check("low_alarm", 32'(alarm_led), 32'd0);
        check("low_err",   32'(err_flag), 32'd1);
        do_reset();
        check("final_err", 32'(err_flag), 32'd0);
        check("final_state", 32'(state), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/temp_fan_ctrl.md
TEMP_FAN_CTRL -- requirements
Module: temp_fan_ctrl

Interface
REQ-001 Parameter PWM_PERIOD, 100, fan PWM period in clk cycles; counter runs 0..PWM_PERIOD-1.
REQ-002 Parameter DEB_CNT, 4, consecutive equal samples required to change class (except entry to DANGER).
REQ-003 Parameter BLINK_DIV, 25_000_000, clk cycles per alarm_led toggle in DANGER.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 temp_class  in  4  one-hot class from the temperature decoder: 1000 low, 0100 normal, 0010 high, 0001 danger.
REQ-008 sample_en  in  1  one-cycle strobe; temp_class is sampled only when this is 1.
REQ-009 fan_pwm  out  1  registered fan drive.
REQ-010 alarm_led  out  1  registered alarm indicator.
REQ-011 state  out  2  current state: 00 LOW, 01 NORMAL, 10 HIGH, 11 DANGER.
REQ-012 err_flag  out  1  sticky flag: a non-one-hot temp_class was sampled.

Function
REQ-013 The block SHALL ignore temp_class on any cycle with sample_en=0.
REQ-014 Debounce: holds candidate class and count; sampled class equal to candidate increments count (saturating at DEB_CNT), otherwise candidate loads the new class and count becomes 1.
REQ-015 The FSM SHALL move to the candidate state on the clock edge that samples the DEB_CNT-th consecutive equal class, when it differs from the current state; any state may jump to any other.
REQ-016 A single sampled danger class SHALL move the FSM to DANGER on that edge, without debounce.
REQ-017 Non-one-hot temp_class (including 0000) SHALL be treated as danger per REQ-016, and SHALL set err_flag, which holds until reset.
REQ-018 Re-sampling the class of the current state SHALL cause no state change.
REQ-019 Duty per state: LOW 0, NORMAL PWM_PERIOD*25/100, HIGH PWM_PERIOD*60/100, DANGER PWM_PERIOD, all integer truncation.
REQ-020 fan_pwm SHALL be 1 exactly when the PWM counter is below the active duty.
REQ-021 The active duty SHALL load from the state only when the counter wraps from PWM_PERIOD-1 to 0, so no period is ever truncated or glitched.
REQ-022 alarm_led: 0 in LOW/NORMAL, steady 1 in HIGH.
REQ-023 In DANGER, alarm_led SHALL be 1 on the first cycle after entry and SHALL toggle every BLINK_DIV cycles; the blink counter clears on each entry into DANGER.
REQ-024 state and alarm_led SHALL change one clk after the qualifying sample_en edge.

Reset
REQ-025 While reset=1 at a clk edge: state=NORMAL, fan_pwm=0, alarm_led=0, err_flag=0, active duty=0, PWM, blink and debounce counters=0, candidate=NORMAL.
REQ-026 Reset SHALL override a same-cycle sample_en and SHALL abort any in-progress PWM period or blink immediately.

Structure
REQ-027 Shared package temp_pkg SHALL hold the state encoding, the four one-hot class constants and the duty percentages (0/25/60/100).
REQ-028 Sub-module pwm_gen SHALL contain the period counter, duty register with wrap-time load, and comparator; the FSM, debounce and alarm logic stay in temp_fan_ctrl.

Verification (PWM_PERIOD=100, DEB_CNT=4, BLINK_DIV=10)
REQ-029 Reset, then 4 strobes of 0010 -> state=10 one clk after 4th strobe, alarm_led=1, fan_pwm high 60 of every 100 clks from next wrap.
REQ-030 From NORMAL: 3 strobes 0010, 1 strobe 0100, 3 strobes 0010 -> state stays 01 throughout.
REQ-031 From NORMAL: one strobe 0001 -> state=11 next clk, alarm_led 1 for 10 clks then toggles every 10; fan_pwm constant 1 from next wrap.
REQ-032 One strobe 0110 -> state=11, err_flag=1; then 4 strobes 0100 -> state=01, err_flag still 1 until reset.
REQ-033 Reset asserted mid-DANGER blink -> after that edge state=01, fan_pwm=0, alarm_led=0, err_flag=0; the PWM period restarts at 0.
REQ-034 temp_class toggled among all 16 codes with sample_en=0 for 200 clks -> state, err_flag and debounce count unchanged.
